matrix_coord_tx: RTL and testbench

//  Driver side of the 4x4 bit-matrix coordinate interface (X, Y, enter in; Z out).

---
 rtl/matrix_pkg.sv | 21 ++
 rtl/matrix_bit_scan.sv | 24 ++
 rtl/matrix_coord_tx.sv | 134 +++++++++++++
 tb/tb_matrix_coord_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the 4x4 bit-matrix coordinate interface.
// Cell index i maps to (X,Y) = (i[1:0], i[3:2]).
package matrix_pkg;

    localparam int MATRIX_DIM   = 4;
    localparam int MATRIX_CELLS = MATRIX_DIM * MATRIX_DIM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_GAP,
        S_QUERY,
        S_ZWAIT,
        S_DONE
    } state_t;

    function automatic logic [3:0] idx_to_xy(input logic [3:0] idx);
        return {idx[3:2], idx[1:0]};
    endfunction

endpackage

// File: rtl/matrix_bit_scan.sv
// Finds the lowest set bit of pattern at an index >= from.
// from=16 is outside the matrix and always reports not found.
module matrix_bit_scan
    import matrix_pkg::*;
(
    input  logic [15:0] pattern,
    input  logic [4:0]  from,
    output logic        found,
    output logic [3:0]  pos
);

    always_comb begin
        found = 1'b0;
        pos   = 4'd0;
        // Descending walk so the last hit written is the lowest qualifying bit.
        for (int i = MATRIX_CELLS - 1; i >= 0; i--) begin
            if (pattern[i] && (5'(i) >= from)) begin
                found = 1'b1;
                pos   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/matrix_coord_tx.sv
// Driver side of the 4x4 matrix coordinate interface: strobes every set
// cell of the pattern (FILL), then reads all 16 cells back through Z (QUERY).
module matrix_coord_tx
    import matrix_pkg::*;
#(
    parameter int Z_LAT     = 2,
    parameter int ENTER_GAP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] pattern,
    output logic [1:0]  X,
    output logic [1:0]  Y,
    output logic        enter,
    input  logic        Z,
    output logic        busy,
    output logic [4:0]  fill_cnt,
    output logic [15:0] readback,
    output logic        done,
    output logic        match
);

    localparam int         WAIT_N    = (Z_LAT > ENTER_GAP) ? Z_LAT : ENTER_GAP;
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_N - 1);
    localparam logic [2:0] GAP_LAST  = 3'(ENTER_GAP - 1);

    state_t      r_state;
    logic [4:0]  r_idx;
    logic [2:0]  r_wcnt;
    logic [15:0] r_pat;
    logic [1:0]  r_x, r_y;
    logic        r_enter, r_busy, r_done, r_match;
    logic [4:0]  r_fill_cnt;
    logic [15:0] r_readback;

    logic        w_found;
    logic [3:0]  w_pos;

    matrix_bit_scan u_scan (
        .pattern (r_pat),
        .from    (r_idx),
        .found   (w_found),
        .pos     (w_pos)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 5'd0;
            r_wcnt     <= 3'd0;
            r_pat      <= 16'd0;
            r_x        <= 2'd0;
            r_y        <= 2'd0;
            r_enter    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_match    <= 1'b0;
            r_fill_cnt <= 5'd0;
            r_readback <= 16'd0;
        end else begin
            r_enter <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pat      <= pattern;
                        r_readback <= 16'd0;
                        r_fill_cnt <= 5'd0;
                        r_match    <= 1'b0;
                        r_idx      <= 5'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_enter <= 1'b1;
                    r_wcnt  <= 3'd0;
                    if (w_found) begin
                        {r_y, r_x} <= idx_to_xy(w_pos);
                        r_fill_cnt <= r_fill_cnt + 5'd1;
                        r_idx      <= {1'b0, w_pos} + 5'd1;
                        r_state    <= (ENTER_GAP > 0) ? S_GAP : S_FILL;
                    end else begin
                        // Scan exhausted: this same cycle issues the query for cell 0.
                        {r_y, r_x} <= idx_to_xy(4'd0);
                        r_idx      <= 5'd0;
                        r_state    <= S_ZWAIT;
                    end
                end
                S_GAP: begin
                    if (r_wcnt == GAP_LAST) r_state <= S_FILL;
                    else                    r_wcnt  <= r_wcnt + 3'd1;
                end
                S_QUERY: begin
                    {r_y, r_x} <= idx_to_xy(r_idx[3:0]);
                    r_enter    <= 1'b1;
                    r_wcnt     <= 3'd0;
                    r_state    <= S_ZWAIT;
                end
                S_ZWAIT: begin
                    if (r_wcnt == WAIT_LAST) begin
                        r_readback[r_idx[3:0]] <= Z;
                        if (r_idx == 5'd15) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= S_QUERY;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + 3'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_match <= (r_readback == r_pat);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign X        = r_x;
    assign Y        = r_y;
    assign enter    = r_enter;
    assign busy     = r_busy;
    assign done     = r_done;
    assign match    = r_match;
    assign fill_cnt = r_fill_cnt;
    assign readback = r_readback;

endmodule

// File: tb/tb_matrix_coord_tx.sv
// Directed bench for matrix_coord_tx: a default instance (Z_LAT=2, no gap) and
// a second instance with ENTER_GAP=2, each answered by a small matrix model.
module tb_matrix_coord_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start_g = 1'b0;
    logic [15:0] pattern = 16'd0, pattern_g = 16'd0;
    logic [1:0]  X, Y, X_g, Y_g;
    logic        enter, enter_g, Z, Z_g, busy, busy_g, done, done_g, match, match_g;
    logic [4:0]  fill_cnt, fill_cnt_g;
    logic [15:0] readback, readback_g;

    int total = 0, bad = 0, cyc = 0, t0 = 0, dc = 0;

    // Matrix models: Z returns the stored cell of the last strobed coordinate.
    logic [15:0] zmem = 16'd0, zmem_g = 16'd0;
    logic [3:0]  zsel = 4'd0, zsel_g = 4'd0;
    assign Z   = zmem[zsel];
    assign Z_g = zmem_g[zsel_g];

    logic [3:0] lg_xy[$], lgg_xy[$];
    int         lg_cyc[$], lgg_cyc[$];

    matrix_coord_tx u_dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .X(X), .Y(Y), .enter(enter), .Z(Z), .busy(busy), .fill_cnt(fill_cnt),
        .readback(readback), .done(done), .match(match)
    );

    matrix_coord_tx #(.Z_LAT(2), .ENTER_GAP(2)) u_dut_g (
        .clk(clk), .rst(rst), .start(start_g), .pattern(pattern_g),
        .X(X_g), .Y(Y_g), .enter(enter_g), .Z(Z_g), .busy(busy_g), .fill_cnt(fill_cnt_g),
        .readback(readback_g), .done(done_g), .match(match_g)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (enter)   zsel   <= {Y, X};
        if (enter_g) zsel_g <= {Y_g, X_g};
    end

    always @(negedge clk) begin
        if (enter)   begin lg_xy.push_back({Y, X});      lg_cyc.push_back(cyc);  end
        if (enter_g) begin lgg_xy.push_back({Y_g, X_g}); lgg_cyc.push_back(cyc); end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Raise start after a posedge; t0 is that cycle, so the DUT samples it at t0+1.
    task automatic go(input logic [15:0] pat, input logic [15:0] zm);
        @(posedge clk); #1;
        zmem = zm; pattern = pat; start = 1'b1; t0 = cyc;
        lg_xy.delete(); lg_cyc.delete();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int lim, output int d);
        d = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk); #1;
            if ((sel ? done_g : done) === 1'b1) begin
                d = cyc;
                break;
            end
        end
        chk("done_seen", 32'(d >= 0), 32'd1);
    endtask

    task automatic chk_query_order(input string tag, input int first);
        int e = 0;
        for (int j = 0; j < 16; j++) begin
            if (lg_xy[first + j] !== 4'(j)) e++;
            if (j > 0 && (lg_cyc[first + j] - lg_cyc[first + j - 1]) != 3) e++;
        end
        chk(tag, 32'(e), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_enter",    32'(enter),    32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_fill",     32'(fill_cnt), 32'd0);
        chk("rst_rb",       32'(readback), 32'd0);
        chk("rst_done_m",   32'({done, match, X, Y}), 32'd0);
        rst = 1'b0;

        // 1: single cell
        go(16'h0001, 16'h0001);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done(1'b0, 200, dc);
        chk("t1_done_cyc", 32'(dc - t0), 32'd51);
        chk("t1_fill",     32'(fill_cnt), 32'd1);
        chk("t1_rb",       32'(readback), 32'h0001);
        chk("t1_match",    32'(match),    32'd1);
        chk("t1_busy_dn",  32'(busy),     32'd0);
        chk("t1_nstrobe",  32'(lg_xy.size()), 32'd17);
        chk("t1_fill_xy",  32'(lg_xy[0]), 32'd0);
        chk("t1_fill_cyc", 32'(lg_cyc[0] - t0), 32'd2);
        chk_query_order("t1_qorder", 1);
        @(negedge clk); #1;
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_hold_match", 32'(match), 32'd1);

        // 2: diagonal, back-to-back strobes at cells 0,5,10,15
        go(16'h8421, 16'h8421);
        wait_done(1'b0, 200, dc);
        chk("t2_fill",  32'(fill_cnt), 32'd4);
        chk("t2_match", 32'(match), 32'd1);
        chk("t2_rb",    32'(readback), 32'h8421);
        chk("t2_xy",    32'({lg_xy[0], lg_xy[1], lg_xy[2], lg_xy[3]}), 32'h05AF);
        chk("t2_b2b",   32'(lg_cyc[3] - lg_cyc[0]), 32'd3);
        chk_query_order("t2_qorder", 4);

        // 3: empty pattern goes straight to QUERY
        go(16'h0000, 16'h0000);
        wait_done(1'b0, 200, dc);
        chk("t3_done_cyc", 32'(dc - t0), 32'd50);
        chk("t3_q0_cyc",   32'(lg_cyc[0] - t0), 32'd2);
        chk("t3_fill",     32'(fill_cnt), 32'd0);
        chk("t3_rb",       32'(readback), 32'd0);
        chk("t3_match",    32'(match), 32'd1);
        chk("t3_nstrobe",  32'(lg_xy.size()), 32'd16);

        // 4: full pattern, cell 6 stuck at 0
        go(16'hFFFF, 16'hFFBF);
        wait_done(1'b0, 200, dc);
        chk("t4_done_cyc", 32'(dc - t0), 32'd66);
        chk("t4_fill",     32'(fill_cnt), 32'd16);
        chk("t4_rb",       32'(readback), 32'hFFBF);
        chk("t4_match",    32'(match), 32'd0);

        // 5a: reset on the third FILL strobe of 16'h00FF
        go(16'h00FF, 16'h00FF);
        dc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (lg_xy.size() == 3) begin dc = i; break; end
        end
        chk("t5_third_strobe", 32'(dc >= 0), 32'd1);
        chk("t5_third_xy",     32'(lg_xy[2]), 32'd2);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t5_enter", 32'(enter), 32'd0);
        chk("t5_busy",  32'(busy), 32'd0);
        chk("t5_fill",  32'(fill_cnt), 32'd0);
        chk("t5_xy",    32'({X, Y}), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("t5_no_strobe", 32'(lg_xy.size()), 32'd3);

        // 5b: start raised mid-run must be ignored
        go(16'h0003, 16'h0003);
        repeat (10) @(posedge clk);
        #1;
        pattern = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, 200, dc);
        chk("t5b_done_cyc", 32'(dc - t0), 32'd52);
        chk("t5b_fill",     32'(fill_cnt), 32'd2);
        chk("t5b_rb",       32'(readback), 32'h0003);
        chk("t5b_match",    32'(match), 32'd1);

        // 6: ENTER_GAP=2 instance
        @(posedge clk); #1;
        zmem_g = 16'h0003; pattern_g = 16'h0003; start_g = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start_g = 1'b0;
        wait_done(1'b1, 300, dc);
        chk("t6_nstrobe", 32'(lgg_xy.size()), 32'd18);
        chk("t6_fill_gap", 32'(lgg_cyc[1] - lgg_cyc[0]), 32'd3);
        chk("t6_first_q",  32'(lgg_cyc[2] - lgg_cyc[1]), 32'd3);
        chk("t6_q_space",  32'(lgg_cyc[3] - lgg_cyc[2]), 32'd3);
        chk("t6_fill_xy",  32'({lgg_xy[0], lgg_xy[1]}), 32'h01);
        chk("t6_fill",     32'(fill_cnt_g), 32'd2);
        chk("t6_rb",       32'(readback_g), 32'h0003);
        chk("t6_match",    32'(match_g), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
